sfifo_thresh: RTL

//  Single-clock, parametrised first-word-fall-through FIFO with registered fill level.

---
 rtl/sfifo_thresh_if.sv | 43 ++++
 rtl/sfifo_thresh.sv | 109 ++++++++++
 2 files changed

// File: rtl/sfifo_thresh_if.sv
// Write/read handshake, fill level and threshold bundle for sfifo_thresh.
// Error-flag signals exist only when SFIFO_ERR_FLAGS_EN is defined.
interface sfifo_thresh_if #(
    parameter int LGFIFO = 4,
    parameter int WIDTH  = 16
);
    logic              i_wr;
    logic [WIDTH-1:0]  i_wr_data;
    logic              o_full;
    logic              i_rd;
    logic [WIDTH-1:0]  o_rd_data;
    logic              o_empty;
    logic [LGFIFO:0]   o_fill;
    logic [LGFIFO:0]   i_af_level;
    logic [LGFIFO:0]   i_ae_level;
    logic              o_almost_full;
    logic              o_almost_empty;
`ifdef SFIFO_ERR_FLAGS_EN
    logic              i_clr_err;
    logic              o_overflow;
    logic              o_underflow;

    modport slave (
        input  i_wr, i_wr_data, i_rd, i_af_level, i_ae_level, i_clr_err,
        output o_full, o_rd_data, o_empty, o_fill, o_almost_full, o_almost_empty,
               o_overflow, o_underflow
    );
    modport master (
        output i_wr, i_wr_data, i_rd, i_af_level, i_ae_level, i_clr_err,
        input  o_full, o_rd_data, o_empty, o_fill, o_almost_full, o_almost_empty,
               o_overflow, o_underflow
    );
`else
    modport slave (
        input  i_wr, i_wr_data, i_rd, i_af_level, i_ae_level,
        output o_full, o_rd_data, o_empty, o_fill, o_almost_full, o_almost_empty
    );
    modport master (
        output i_wr, i_wr_data, i_rd, i_af_level, i_ae_level,
        input  o_full, o_rd_data, o_empty, o_fill, o_almost_full, o_almost_empty
    );
`endif
endinterface

// File: rtl/sfifo_thresh.sv
// FWFT FIFO, write->head visible next cycle; flags are flops of next fill; writes refused when full
// (unless write-on-full with a same-cycle read), empty reads ignored. SFIFO_ERR_FLAGS_EN adds sticky errors.
module sfifo_thresh #(
    parameter int LGFIFO             = 4,
    parameter int WIDTH              = 16,
    parameter bit OPT_WRITE_ON_FULL  = 1'b0,
    parameter bit OPT_REGISTER_READS = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    sfifo_thresh_if.slave bus
);
    localparam logic [LGFIFO:0] L_ONE   = {{LGFIFO{1'b0}}, 1'b1};
    localparam logic [LGFIFO:0] L_DEPTH = {1'b1, {LGFIFO{1'b0}}};

    logic [WIDTH-1:0] r_mem [2**LGFIFO];
    logic [LGFIFO:0]  r_wr_addr, r_rd_addr, r_fill;
    logic [LGFIFO:0]  w_fill_nxt, w_rd_addr_nxt;
    logic             r_full, r_empty, r_almost_full, r_almost_empty;
    logic             w_rd_ok, w_wr_ok;

    assign w_rd_ok       = bus.i_rd && !r_empty;
    assign w_wr_ok       = bus.i_wr && (!r_full || (OPT_WRITE_ON_FULL && bus.i_rd));
    assign w_rd_addr_nxt = w_rd_ok ? (r_rd_addr + L_ONE) : r_rd_addr;

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_wr_ok && !w_rd_ok)
            w_fill_nxt = r_fill + L_ONE;
        else if (w_rd_ok && !w_wr_ok)
            w_fill_nxt = r_fill - L_ONE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_addr      <= '0;
            r_rd_addr      <= '0;
            r_fill         <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_ok)
                r_wr_addr <= r_wr_addr + L_ONE;
            r_rd_addr      <= w_rd_addr_nxt;
            r_fill         <= w_fill_nxt;
            r_full         <= (w_fill_nxt == L_DEPTH);
            r_empty        <= (w_fill_nxt == '0);
            r_almost_full  <= (w_fill_nxt >= bus.i_af_level);
            r_almost_empty <= (w_fill_nxt <= bus.i_ae_level);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok)
            r_mem[r_wr_addr[LGFIFO-1:0]] <= bus.i_wr_data;
    end

    generate
        if (OPT_REGISTER_READS) begin : g_reg_rd
            logic [WIDTH-1:0] r_rd_data;
            logic             w_bypass;

            // Next head slot is the one being written now: memory is not yet updated.
            assign w_bypass = w_wr_ok && (w_rd_addr_nxt == r_wr_addr);

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n)
                    r_rd_data <= '0;
                else if (w_rd_ok || w_wr_ok)
                    r_rd_data <= w_bypass ? bus.i_wr_data : r_mem[w_rd_addr_nxt[LGFIFO-1:0]];
            end
            assign bus.o_rd_data = r_rd_data;
        end else begin : g_comb_rd
            assign bus.o_rd_data = r_mem[r_rd_addr[LGFIFO-1:0]];
        end
    endgenerate

    assign bus.o_full         = r_full;
    assign bus.o_empty        = r_empty;
    assign bus.o_fill         = r_fill;
    assign bus.o_almost_full  = r_almost_full;
    assign bus.o_almost_empty = r_almost_empty;

`ifdef SFIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;

    // A new error in the same cycle as a clear wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.i_wr && !w_wr_ok)
                r_overflow <= 1'b1;
            else if (bus.i_clr_err)
                r_overflow <= 1'b0;
            if (bus.i_rd && r_empty)
                r_underflow <= 1'b1;
            else if (bus.i_clr_err)
                r_underflow <= 1'b0;
        end
    end

    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;
`endif
endmodule
